// File: rtl/phase_driver_pkg.sv
// Shared types and derived-timing helpers for the phased square-wave driver.
package phase_driver_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } state_e;

    function automatic int unsigned calc_period(input int unsigned clk_freq,
                                                input int unsigned out_freq);
        return clk_freq / out_freq;
    endfunction

    function automatic int unsigned calc_half(input int unsigned clk_freq,
                                              input int unsigned out_freq);
        return calc_period(clk_freq, out_freq) / 2;
    endfunction

    function automatic int unsigned calc_cw(input int unsigned clk_freq,
                                            input int unsigned out_freq);
        return $clog2(calc_period(clk_freq, out_freq));
    endfunction

endpackage

// File: rtl/phase_channel.sv
// One drive channel: shadow phase register with clamp, modular offset from the
// shared counter, and the high/low decision for the first half of the period.
module phase_channel
    import phase_driver_pkg::*;
#(
    parameter int unsigned ClkFreq = 50_000_000,
    parameter int unsigned OutFreq = 40_000,
    localparam int unsigned Period = calc_period(ClkFreq, OutFreq),
    localparam int unsigned Half   = calc_half(ClkFreq, OutFreq),
    localparam int unsigned Cw     = calc_cw(ClkFreq, OutFreq)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [Cw-1:0] cnt_i,
    input  logic          wrap_i,
    input  logic          load_en_i,
    input  logic [Cw-1:0] phase_i,
    output logic          hi_o,
    output logic          clamp_flag_o
);

    // One extra bit so a power-of-two period and cnt + Period never overflow.
    localparam logic [Cw:0]   PeriodW = (Cw+1)'(Period);
    localparam logic [Cw:0]   HalfW   = (Cw+1)'(Half);
    localparam logic [Cw-1:0] LastW   = Cw'(Period - 1);

    logic [Cw-1:0] act_q, act_d;
    logic          load;
    logic          over;
    logic [Cw:0]   cnt_w, act_w, diff;

    assign load  = wrap_i & load_en_i;
    assign over  = ({1'b0, phase_i} >= PeriodW);
    assign cnt_w = {1'b0, cnt_i};
    assign act_w = {1'b0, act_q};

    always_comb begin
        act_d = act_q;
        if (load) begin
            act_d = over ? LastW : phase_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            act_q <= '0;
        end else begin
            act_q <= act_d;
        end
    end

    assign diff         = (cnt_w >= act_w) ? (cnt_w - act_w) : (cnt_w + PeriodW - act_w);
    assign hi_o         = (diff < HalfW);
    assign clamp_flag_o = load & over;

endmodule

// File: rtl/phase_driver.sv
// Multi-channel phased square-wave generator: shared period counter, run/idle
// FSM gating the registered outputs, and a sticky flag for out-of-range phases.
module phase_driver
    import phase_driver_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = 50_000_000,
    parameter int unsigned OUT_FREQ     = 40_000,
    parameter int unsigned NUM_CHANNELS = 64,
    localparam int unsigned PERIOD      = calc_period(CLK_FREQ, OUT_FREQ),
    localparam int unsigned CW          = calc_cw(CLK_FREQ, OUT_FREQ)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_CHANNELS-1:0][CW-1:0]  phases,
    input  logic                             enable,
    output logic [NUM_CHANNELS-1:0]          drive_out,
    output logic                             period_start,
    output logic                             running,
    output logic                             phase_error
);

    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    wrap;
    state_e                  state_q, state_d;
    logic [NUM_CHANNELS-1:0] drive_q, drive_d;
    logic                    period_start_q;
    logic                    phase_error_q;
    logic [NUM_CHANNELS-1:0] hi;
    logic [NUM_CHANNELS-1:0] clamp;

    assign wrap  = (cnt_q == CW'(PERIOD - 1));
    assign cnt_d = wrap ? '0 : cnt_q + 1'b1;

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        phase_channel #(
            .ClkFreq (CLK_FREQ),
            .OutFreq (OUT_FREQ)
        ) u_ch (
            .clk_i        (clk),
            .rst_ni       (rst_n),
            .cnt_i        (cnt_q),
            .wrap_i       (wrap),
            .load_en_i    (1'b1),
            .phase_i      (phases[i]),
            .hi_o         (hi[i]),
            .clamp_flag_o (clamp[i])
        );
    end

    // Dropping enable leaves RUN and zeroes the outputs on the same edge.
    always_comb begin
        state_d = state_q;
        drive_d = '0;
        unique case (state_q)
            StIdle: begin
                if (wrap && enable) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (!enable) begin
                    state_d = StIdle;
                end else begin
                    drive_d = hi;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q          <= '0;
            state_q        <= StIdle;
            drive_q        <= '0;
            period_start_q <= 1'b0;
            phase_error_q  <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            state_q        <= state_d;
            drive_q        <= drive_d;
            period_start_q <= wrap;
            phase_error_q  <= phase_error_q | (|clamp);
        end
    end

    assign drive_out    = drive_q;
    assign period_start = period_start_q;
    assign running      = (state_q == StRun);
    assign phase_error  = phase_error_q;

endmodule

// File: tb/tb_phase_driver.sv
// Bench for phase_driver: cycle scoreboard from a behavioural model, steady-state
// waveform tables, and hand-built enable/reset corner sequences.
module tb_phase_driver;

    localparam int unsigned NCH = 4;
    localparam int unsigned P   = 10;
    localparam int unsigned H   = 5;
    localparam int unsigned W   = 4;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     enable;
    logic [NCH-1:0][W-1:0]    phases;
    logic [NCH-1:0]           drive_out;
    logic                     period_start;
    logic                     running;
    logic                     phase_error;

    always #5 clk = ~clk;

    phase_driver #(
        .CLK_FREQ     (1000),
        .OUT_FREQ     (100),
        .NUM_CHANNELS (NCH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .phases       (phases),
        .enable       (enable),
        .drive_out    (drive_out),
        .period_start (period_start),
        .running      (running),
        .phase_error  (phase_error)
    );

    typedef struct packed {
        logic [NCH-1:0] drive;
        logic           ps;
        logic           run;
        logic           err;
    } exp_t;

    typedef struct {
        logic [NCH-1:0][W-1:0] ph;
        logic [10*NCH-1:0]     pat;  // nibble c = expected drive for counter value c
        logic                  err;
    } vec_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // Reference model, advanced on every rising edge from the inputs the bench drove.
    int m_cnt = 0;
    int m_act [NCH];
    bit m_run = 1'b0;
    bit m_err = 1'b0;

    always @(posedge clk) begin : model
        exp_t e;
        bit   w;
        e = '0;
        if (!rst_n) begin
            m_cnt = 0;
            foreach (m_act[i]) m_act[i] = 0;
            m_run = 1'b0;
            m_err = 1'b0;
        end else begin
            w = (m_cnt == P - 1);
            if (m_run && enable) begin
                for (int i = 0; i < NCH; i++) begin
                    e.drive[i] = (((m_cnt - m_act[i] + P) % P) < H);
                end
            end
            e.ps = w;
            if (w) begin
                for (int i = 0; i < NCH; i++) begin
                    if (phases[i] >= P) begin
                        m_act[i] = P - 1;
                        m_err    = 1'b1;
                    end else begin
                        m_act[i] = int'(phases[i]);
                    end
                end
            end
            if (m_run) begin
                if (!enable) m_run = 1'b0;
            end else if (w && enable) begin
                m_run = 1'b1;
            end
            m_cnt = (m_cnt + 1) % P;
            e.run = m_run;
            e.err = m_err;
        end
        sb_q.push_back(e);
    end

    always @(negedge clk) begin : scoreboard
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("sb_drive_out", drive_out, e.drive);
            chk("sb_period_start", period_start, e.ps);
            chk("sb_running", running, e.run);
            chk("sb_phase_error", phase_error, e.err);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ps();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3 * P; i++) begin
            @(negedge clk);
            if (period_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        chk("period_start_bound", ok, 1);
    endtask

    task automatic cycles_to_run(input string name, input int want);
        int n;
        n = 0;
        for (int i = 0; i < 3 * P; i++) begin
            @(negedge clk);
            n++;
            if (running === 1'b1) break;
        end
        chk(name, n, want);
    endtask

    vec_t vecs [3];

    initial begin
        vecs[0] = '{ph: {4'd9, 4'd8, 4'd3, 4'd0},  pat: 40'hC4222_3BDDD, err: 1'b0};
        vecs[1] = '{ph: {4'd9, 4'd12, 4'd3, 4'd0}, pat: 40'hC0222_3FDDD, err: 1'b1};
        vecs[2] = '{ph: {4'd5, 4'd2, 4'd6, 4'd0},  pat: 40'hAAAEC_55513, err: 1'b1};

        rst_n  = 1'b0;
        enable = 1'b0;
        phases = '0;
        tick(3);
        chk("reset_drive_out", drive_out, 0);
        chk("reset_running", running, 0);
        chk("reset_phase_error", phase_error, 0);
        chk("reset_period_start", period_start, 0);

        // Enable held through reset release: RUN exactly at the first wrap.
        enable = 1'b1;
        rst_n  = 1'b1;
        cycles_to_run("run_after_reset_cycles", 10);

        for (int v = 0; v < 3; v++) begin
            logic [10*NCH-1:0] pat;
            pat    = vecs[v].pat;
            phases = vecs[v].ph;
            wait_ps();
            wait_ps();
            chk("tbl_phase_error", phase_error, vecs[v].err);
            for (int k = 0; k < int'(P); k++) begin
                int c;
                c = (k + int'(P) - 1) % int'(P);
                chk($sformatf("tbl%0d_drive_cnt%0d", v, c), drive_out, pat[c*4 +: 4]);
                tick(1);
            end
        end

        // Mid-period phase change on ch1 only takes effect after the wrap.
        phases = vecs[0].ph;
        wait_ps();
        wait_ps();
        tick(4);
        phases[1] = 4'd6;
        tick(2 * P);

        // Disable mid-period, then re-enable at cnt=3.
        wait_ps();
        tick(6);
        enable = 1'b0;
        tick(1);
        chk("disable_drive_out", drive_out, 0);
        chk("disable_running", running, 0);
        wait_ps();
        tick(3);
        enable = 1'b1;
        cycles_to_run("reenable_cycles", 7);
        tick(2 * P);

        // One-cycle reset in the middle of RUN.
        wait_ps();
        tick(7);
        rst_n = 1'b0;
        tick(1);
        chk("midreset_drive_out", drive_out, 0);
        chk("midreset_running", running, 0);
        chk("midreset_period_start", period_start, 0);
        chk("midreset_phase_error", phase_error, 0);
        rst_n = 1'b1;
        cycles_to_run("run_after_midreset_cycles", 10);
        tick(2 * P);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
